conv3x3_window_feeder: RTL and testbench

Streaming source for the 3x3 convolution MAC pipeline. It accepts a raster-order pixel stream, holds the two previous image rows in line buffers and builds a 3x3 sliding window. It presents the window as nine row-major operands with the valid strobe for the multiplier stage. It also generates the per-stage enable vector for the four downstream adder stages, plus a result-valid flag aligned with the pipeline's registered output.

---
 rtl/conv3x3_window_feeder.sv | 142 ++++++++++++++
 tb/tb_conv3x3_window_feeder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_window_feeder
// Description : Turns a raster-order pixel stream into a 3x3 sliding window.
//               Two line buffers hold the previous rows. The block also emits
//               stage enables for the downstream MAC/adder pipeline, a
//               result-valid flag and an end-of-frame pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_window_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] w1,
  output logic [DATA_WIDTH-1:0] w2,
  output logic [DATA_WIDTH-1:0] w3,
  output logic [DATA_WIDTH-1:0] w4,
  output logic [DATA_WIDTH-1:0] w5,
  output logic [DATA_WIDTH-1:0] w6,
  output logic [DATA_WIDTH-1:0] w7,
  output logic [DATA_WIDTH-1:0] w8,
  output logic [DATA_WIDTH-1:0] w9,
  output logic                  win_valid,
  output logic [3:0]            valid_pipe,
  output logic                  result_valid,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] c_COL_MIN  = CW'(2);
  localparam logic [RW-1:0] c_ROW_MIN  = RW'(2);

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];  // row r-1
  logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];  // row r-2
  logic [DATA_WIDTH-1:0] r_win [9];          // row-major, index 0 = top-left
  logic                  r_win_valid;
  logic [3:0]            r_valid_pipe;
  logic                  r_result_valid;
  logic                  r_frame_done;

  logic [DATA_WIDTH-1:0] w_lb0_rd;
  logic [DATA_WIDTH-1:0] w_lb1_rd;
  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_win_pos;

  assign w_lb0_rd   = r_lb0[r_col];
  assign w_lb1_rd   = r_lb1[r_col];
  assign w_last_col = (r_col == c_COL_LAST);
  assign w_last_row = (r_row == c_ROW_LAST);
  // A window is complete only once two full rows and two columns precede it
  // within the same row, so row-boundary and frame-start windows never flag.
  assign w_win_pos  = (r_row >= c_ROW_MIN) && (r_col >= c_COL_MIN);

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pix_valid) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers: not reset, rows 0-1 of every frame rewrite them first.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= pix_in;
    end
  end

  // Window shifts left on accept; new right column comes from the buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else if (pix_valid) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb1_rd;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb0_rd;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pix_in;
    end
  end

  // Window-valid and end-of-frame strobes, one cycle per accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= pix_valid && w_win_pos;
      r_frame_done <= pix_valid && w_last_col && w_last_row;
    end
  end

  // Free-running stage-enable shift register; bubbles pass straight through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_pipe   <= 4'b0000;
      r_result_valid <= 1'b0;
    end else begin
      r_valid_pipe   <= {r_valid_pipe[2:0], r_win_valid};
      r_result_valid <= r_valid_pipe[3];
    end
  end

  assign w1           = r_win[0];
  assign w2           = r_win[1];
  assign w3           = r_win[2];
  assign w4           = r_win[3];
  assign w5           = r_win[4];
  assign w6           = r_win[5];
  assign w7           = r_win[6];
  assign w8           = r_win[7];
  assign w9           = r_win[8];
  assign win_valid    = r_win_valid;
  assign valid_pipe   = r_valid_pipe;
  assign result_valid = r_result_valid;
  assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv3x3_window_feeder
// Description : Self-checking bench for conv3x3_window_feeder. A 4x4 and a
//               5x3 instance share the clock; an image-array reference model
//               predicts every window from raster coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_window_feeder;

  logic        clk;
  logic        rst;
  logic [31:0] pd;
  logic        pv;
  logic        sel;  // 0 selects the 4x4 instance, 1 the 5x3 instance

  logic [31:0] a_w [9];
  logic [31:0] b_w [9];
  logic        a_wv, b_wv, a_fd, b_fd, a_rv, b_rv;
  logic [3:0]  a_vp, b_vp;

  logic [31:0] obs_w [9];
  logic        obs_wv, obs_fd, obs_rv;
  logic [3:0]  obs_vp;

  int npass = 0;
  int nchk  = 0;

  // reference model state
  int          mW, mH, m_r, m_c;
  logic [31:0] img [8][8];
  logic [31:0] exp_w [9];
  logic        exp_wv, exp_fd, exp_rv;
  logic [3:0]  exp_vp;
  bit          known;
  int          nwin, nres;
  logic [31:0] cap [8][9];

  conv3x3_window_feeder #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_d44 (
    .clk(clk), .rst(rst), .pix_in(pd), .pix_valid(pv & ~sel),
    .w1(a_w[0]), .w2(a_w[1]), .w3(a_w[2]), .w4(a_w[3]), .w5(a_w[4]),
    .w6(a_w[5]), .w7(a_w[6]), .w8(a_w[7]), .w9(a_w[8]),
    .win_valid(a_wv), .valid_pipe(a_vp), .result_valid(a_rv), .frame_done(a_fd)
  );

  conv3x3_window_feeder #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(3)) u_d53 (
    .clk(clk), .rst(rst), .pix_in(pd), .pix_valid(pv & sel),
    .w1(b_w[0]), .w2(b_w[1]), .w3(b_w[2]), .w4(b_w[3]), .w5(b_w[4]),
    .w6(b_w[5]), .w7(b_w[6]), .w8(b_w[7]), .w9(b_w[8]),
    .win_valid(b_wv), .valid_pipe(b_vp), .result_valid(b_rv), .frame_done(b_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 9; k++) obs_w[k] = sel ? b_w[k] : a_w[k];
    obs_wv = sel ? b_wv : a_wv;
    obs_fd = sel ? b_fd : a_fd;
    obs_rv = sel ? b_rv : a_rv;
    obs_vp = sel ? b_vp : a_vp;
  end

  task automatic model_reset();
    m_r = 0; m_c = 0;
    exp_wv = 1'b0; exp_fd = 1'b0; exp_rv = 1'b0; exp_vp = 4'b0000;
    for (int k = 0; k < 9; k++) exp_w[k] = '0;
    known = 1'b1;
    nwin = 0; nres = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; pv = 1'b0; pd = '0;
    mW = sel ? 5 : 4;
    mH = sel ? 3 : 4;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle, then advance the reference model from image coordinates.
  task automatic step(input logic v, input logic [31:0] d);
    pv = v; pd = d;
    @(posedge clk);
    #1;
    exp_rv = exp_vp[3];
    exp_vp = {exp_vp[2:0], exp_wv};
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    if (v) begin
      img[m_r][m_c] = d;
      if (m_r >= 2 && m_c >= 2) begin
        exp_wv = 1'b1;
        known  = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_w[i*3+j] = img[m_r-2+i][m_c-2+j];
      end else begin
        known = 1'b0;
      end
      exp_fd = (m_r == mH-1) && (m_c == mW-1);
      if (m_c == mW-1) begin
        m_c = 0;
        m_r = (m_r == mH-1) ? 0 : m_r + 1;
      end else begin
        m_c = m_c + 1;
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; rst = 1'b1; pv = 1'b1; pd = 32'hDEAD_BEEF;
    #1;
    for (int k = 0; k < 9; k++) begin
      nchk++;
      if (obs_w[k] !== 32'd0) $display("FAIL reset w%0d: got %0h want 0", k+1, obs_w[k]);
      else npass++;
    end
    nchk++;
    if ({obs_wv, obs_fd, obs_vp, obs_rv} !== 7'd0)
      $display("FAIL reset flags: got wv=%b fd=%b vp=%b rv=%b want all 0", obs_wv, obs_fd, obs_vp, obs_rv);
    else npass++;
    reset_dut();
  endtask

  task automatic test_frame();
    logic [31:0] want_first [9];
    logic [31:0] want_last [9];
    int nfd;
    want_first = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    want_last  = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
    nfd = 0;
    sel = 1'b0; reset_dut();
    for (int p = 1; p <= 22; p++) begin
      step(p <= 16, (p <= 16) ? 32'(p) : 32'd0);
      nchk++;
      if ({obs_wv, obs_fd, obs_vp, obs_rv} !== {exp_wv, exp_fd, exp_vp, exp_rv})
        $display("FAIL frame flags p%0d: got wv=%b fd=%b vp=%b rv=%b want wv=%b fd=%b vp=%b rv=%b",
                 p, obs_wv, obs_fd, obs_vp, obs_rv, exp_wv, exp_fd, exp_vp, exp_rv);
      else npass++;
      if (known) for (int k = 0; k < 9; k++) begin
        nchk++;
        if (obs_w[k] !== exp_w[k]) $display("FAIL frame w%0d p%0d: got %0d want %0d", k+1, p, obs_w[k], exp_w[k]);
        else npass++;
      end
      if (obs_wv === 1'b1) begin
        if (obs_fd !== 1'b1 && nwin == 3) nfd = nfd - 100;
        for (int k = 0; k < 9; k++) cap[nwin % 8][k] = obs_w[k];
        nwin++;
      end
      if (obs_fd === 1'b1) nfd++;
    end
    nchk++;
    if (nwin !== 4) $display("FAIL frame window count: got %0d want 4", nwin); else npass++;
    nchk++;
    if (nfd !== 1) $display("FAIL frame frame_done pulses: got %0d want 1 (in last window)", nfd); else npass++;
    for (int k = 0; k < 9; k++) begin
      nchk++;
      if (cap[0][k] !== want_first[k] || cap[3][k] !== want_last[k])
        $display("FAIL frame fixed w%0d: got first=%0d last=%0d want first=%0d last=%0d",
                 k+1, cap[0][k], cap[3][k], want_first[k], want_last[k]);
      else npass++;
    end
  endtask

  task automatic test_stage_enable();
    sel = 1'b0; reset_dut();
    for (int p = 1; p <= 19; p++) begin
      step(p <= 11, (p <= 11) ? 32'(p) : 32'd0);
      nchk++;
      if ({obs_wv, obs_fd, obs_vp, obs_rv} !== {exp_wv, exp_fd, exp_vp, exp_rv})
        $display("FAIL stage flags c%0d: got wv=%b fd=%b vp=%b rv=%b want wv=%b fd=%b vp=%b rv=%b",
                 p, obs_wv, obs_fd, obs_vp, obs_rv, exp_wv, exp_fd, exp_vp, exp_rv);
      else npass++;
      if (obs_wv === 1'b1) nwin++;
      if (obs_rv === 1'b1) nres++;
    end
    nchk++;
    if (nwin !== 1 || nres !== 1)
      $display("FAIL stage pulse counts: got win=%0d res=%0d want win=1 res=1", nwin, nres);
    else npass++;
  endtask

  task automatic test_gaps();
    sel = 1'b0; reset_dut();
    for (int p = 1; p <= 17; p++) begin
      for (int g = 0; g < 4; g++) begin
        step(g == 0 && p <= 16, (g == 0 && p <= 16) ? 32'(p) : 32'd0);
        nchk++;
        if ({obs_wv, obs_fd, obs_vp, obs_rv} !== {exp_wv, exp_fd, exp_vp, exp_rv})
          $display("FAIL gaps flags p%0d g%0d: got wv=%b fd=%b vp=%b rv=%b want wv=%b fd=%b vp=%b rv=%b",
                   p, g, obs_wv, obs_fd, obs_vp, obs_rv, exp_wv, exp_fd, exp_vp, exp_rv);
        else npass++;
        if (known) for (int k = 0; k < 9; k++) begin
          nchk++;
          if (obs_w[k] !== exp_w[k]) $display("FAIL gaps w%0d p%0d g%0d: got %0d want %0d", k+1, p, g, obs_w[k], exp_w[k]);
          else npass++;
        end
        if (obs_wv === 1'b1) nwin++;
      end
    end
    nchk++;
    if (nwin !== 4) $display("FAIL gaps window cycles: got %0d want 4", nwin); else npass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] want2 [9];
    logic [31:0] d;
    want2 = '{101, 102, 103, 105, 106, 107, 109, 110, 111};
    sel = 1'b0; reset_dut();
    for (int p = 0; p < 38; p++) begin
      d = (p < 16) ? 32'(p + 1) : (p < 32) ? 32'(p - 16 + 101) : 32'd0;
      step(p < 32, d);
      nchk++;
      if ({obs_wv, obs_fd, obs_vp, obs_rv} !== {exp_wv, exp_fd, exp_vp, exp_rv})
        $display("FAIL b2b flags p%0d: got wv=%b fd=%b vp=%b rv=%b want wv=%b fd=%b vp=%b rv=%b",
                 p, obs_wv, obs_fd, obs_vp, obs_rv, exp_wv, exp_fd, exp_vp, exp_rv);
      else npass++;
      if (known) for (int k = 0; k < 9; k++) begin
        nchk++;
        if (obs_w[k] !== exp_w[k]) $display("FAIL b2b w%0d p%0d: got %0d want %0d", k+1, p, obs_w[k], exp_w[k]);
        else npass++;
      end
      if (obs_wv === 1'b1) begin
        for (int k = 0; k < 9; k++) cap[nwin % 8][k] = obs_w[k];
        nwin++;
      end
    end
    nchk++;
    if (nwin !== 8) $display("FAIL b2b window count: got %0d want 8", nwin); else npass++;
    for (int k = 0; k < 9; k++) begin
      nchk++;
      if (cap[4][k] !== want2[k]) $display("FAIL b2b frame2 first w%0d: got %0d want %0d", k+1, cap[4][k], want2[k]);
      else npass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] want_first [9];
    want_first = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    sel = 1'b0; reset_dut();
    for (int p = 1; p <= 10; p++) step(1'b1, 32'(p));
    pv = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 9; k++) begin
      nchk++;
      if (obs_w[k] !== 32'd0) $display("FAIL midrst w%0d: got %0d want 0", k+1, obs_w[k]);
      else npass++;
    end
    nchk++;
    if ({obs_wv, obs_fd, obs_vp, obs_rv} !== 7'd0)
      $display("FAIL midrst flags: got wv=%b fd=%b vp=%b rv=%b want all 0", obs_wv, obs_fd, obs_vp, obs_rv);
    else npass++;
    reset_dut();
    for (int p = 1; p <= 22; p++) begin
      step(p <= 16, (p <= 16) ? 32'(p) : 32'd0);
      nchk++;
      if ({obs_wv, obs_fd, obs_vp, obs_rv} !== {exp_wv, exp_fd, exp_vp, exp_rv})
        $display("FAIL midrst flags p%0d: got wv=%b fd=%b vp=%b rv=%b want wv=%b fd=%b vp=%b rv=%b",
                 p, obs_wv, obs_fd, obs_vp, obs_rv, exp_wv, exp_fd, exp_vp, exp_rv);
      else npass++;
      if (known) for (int k = 0; k < 9; k++) begin
        nchk++;
        if (obs_w[k] !== exp_w[k]) $display("FAIL midrst w%0d p%0d: got %0d want %0d", k+1, p, obs_w[k], exp_w[k]);
        else npass++;
      end
      if (obs_wv === 1'b1) begin
        for (int k = 0; k < 9; k++) cap[nwin % 8][k] = obs_w[k];
        nwin++;
      end
    end
    nchk++;
    if (nwin !== 4) $display("FAIL midrst window count: got %0d want 4", nwin); else npass++;
    for (int k = 0; k < 9; k++) begin
      nchk++;
      if (cap[0][k] !== want_first[k]) $display("FAIL midrst first w%0d: got %0d want %0d", k+1, cap[0][k], want_first[k]);
      else npass++;
    end
  endtask

  task automatic test_min_size();
    logic [31:0] want [3][9];
    want = '{'{1, 2, 3, 6, 7, 8, 11, 12, 13},
             '{2, 3, 4, 7, 8, 9, 12, 13, 14},
             '{3, 4, 5, 8, 9, 10, 13, 14, 15}};
    sel = 1'b1; reset_dut();
    for (int p = 1; p <= 21; p++) begin
      step(p <= 15, (p <= 15) ? 32'(p) : 32'd0);
      nchk++;
      if ({obs_wv, obs_fd, obs_vp, obs_rv} !== {exp_wv, exp_fd, exp_vp, exp_rv})
        $display("FAIL min flags p%0d: got wv=%b fd=%b vp=%b rv=%b want wv=%b fd=%b vp=%b rv=%b",
                 p, obs_wv, obs_fd, obs_vp, obs_rv, exp_wv, exp_fd, exp_vp, exp_rv);
      else npass++;
      if (obs_wv === 1'b1) begin
        for (int k = 0; k < 9; k++) cap[nwin % 8][k] = obs_w[k];
        nwin++;
      end
    end
    nchk++;
    if (nwin !== 3) $display("FAIL min window count: got %0d want 3", nwin); else npass++;
    for (int n = 0; n < 3; n++)
      for (int k = 0; k < 9; k++) begin
        nchk++;
        if (cap[n][k] !== want[n][k]) $display("FAIL min win%0d w%0d: got %0d want %0d", n, k+1, cap[n][k], want[n][k]);
        else npass++;
      end
  endtask

  task automatic test_random();
    logic [31:0] d;
    int gaps;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; reset_dut();
      for (int p = 0; p < 3 * mW * mH; p++) begin
        gaps = $urandom_range(0, 2);
        for (int g = 0; g <= gaps; g++) begin
          d = $urandom;
          step(g == gaps, d);
          nchk++;
          if ({obs_wv, obs_fd, obs_vp, obs_rv} !== {exp_wv, exp_fd, exp_vp, exp_rv})
            $display("FAIL rand%0d flags p%0d: got wv=%b fd=%b vp=%b rv=%b want wv=%b fd=%b vp=%b rv=%b",
                     s, p, obs_wv, obs_fd, obs_vp, obs_rv, exp_wv, exp_fd, exp_vp, exp_rv);
          else npass++;
          if (known) for (int k = 0; k < 9; k++) begin
            nchk++;
            if (obs_w[k] !== exp_w[k]) $display("FAIL rand%0d w%0d p%0d: got %0h want %0h", s, k+1, p, obs_w[k], exp_w[k]);
            else npass++;
          end
        end
      end
    end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; pv = 1'b0; pd = '0;
    mW = 4; mH = 4;
    model_reset();
    test_reset();
    test_frame();
    test_stage_enable();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_min_size();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
